// File: rtl/nw_pkg.sv
// -----------------------------------------------------------------------------
// nw_pkg
// Shared definitions for the Needleman-Wunsch traceback path. The direction
// codes are also used by the direction-RAM writer, so both sides agree on them.
//
// Contents:
//   DIR_DIAG / DIR_UP / DIR_LEFT  one-hot 3-bit arrow codes
//   tb_state_e                    traceback FSM state encoding
//   dir_is_code()                 true when a 3-bit value is one of the arrows
// -----------------------------------------------------------------------------
package nw_pkg;

    localparam logic [2:0] DIR_DIAG = 3'b001;
    localparam logic [2:0] DIR_UP   = 3'b010;
    localparam logic [2:0] DIR_LEFT = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4,
        ST_ERR    = 3'd5
    } tb_state_e;

    function automatic logic dir_is_code(input logic [2:0] d);
        return (d == DIR_DIAG) || (d == DIR_UP) || (d == DIR_LEFT);
    endfunction

endpackage

// File: rtl/tb_step_decode.sv
// -----------------------------------------------------------------------------
// tb_step_decode
// Combinational step decoder: given an arrow and the current cell, produces
// the next cell and flags arrows that are unknown or would walk off the matrix.
//
// Ports:
//   dir     in   3  arrow read from the direction RAM
//   ci, cj  in   W  current cell coordinates
//   next_i  out  W  coordinates after following the arrow
//   next_j  out  W
//   illegal out  1  unknown code, or move past row/column 0
// -----------------------------------------------------------------------------
module tb_step_decode
    import nw_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [2:0]   dir,
    input  logic [W-1:0] ci,
    input  logic [W-1:0] cj,
    output logic [W-1:0] next_i,
    output logic [W-1:0] next_j,
    output logic         illegal
);

    logic i_zero;
    logic j_zero;

    assign i_zero = (ci == '0);
    assign j_zero = (cj == '0);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned; that is what keeps this block free of latches.
        next_i  = ci;
        next_j  = cj;
        illegal = !dir_is_code(dir);
        case (dir)
            DIR_DIAG: begin
                if (i_zero || j_zero) begin
                    illegal = 1'b1;
                end else begin
                    next_i = ci - 1'b1;
                    next_j = cj - 1'b1;
                end
            end
            // UP walks along j, LEFT walks along i.
            DIR_UP: begin
                if (j_zero) illegal = 1'b1;
                else        next_j  = cj - 1'b1;
            end
            DIR_LEFT: begin
                if (i_zero) illegal = 1'b1;
                else        next_i  = ci - 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/traceback_unit.sv
// -----------------------------------------------------------------------------
// traceback_unit
// Walks the direction RAM from (len_i, len_j) back to (0,0), one cell per
// READ -> WAIT -> EMIT round, and streams each step out through a
// valid/ready handshake. Cell (0,0) is the terminus and is never read.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle launch pulse, ignored while busy
//   len_i, len_j          start coordinates, sampled on an accepted start
//   en_traceB, i_t, j_t   direction-RAM read enable and address
//   symbol_out            RAM read data, valid the cycle after en_traceB
//   step_valid/ready      step-stream handshake
//   step_dir/i/j          arrow and cell of the presented step
//   busy, done, error     status; done and error are one-cycle pulses
//   step_cnt              (TRACEBACK_STEP_CNT_EN only) transferred step count
//
// Build option: define TRACEBACK_STEP_CNT_EN to add the step_cnt output.
// -----------------------------------------------------------------------------
module traceback_unit
    import nw_pkg::*;
#(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BitAddr:0] len_i,
    input  logic [BitAddr:0] len_j,
    output logic             en_traceB,
    output logic [BitAddr:0] i_t,
    output logic [BitAddr:0] j_t,
    input  logic [2:0]       symbol_out,
    output logic             step_valid,
    input  logic             step_ready,
    output logic [2:0]       step_dir,
    output logic [BitAddr:0] step_i,
    output logic [BitAddr:0] step_j,
    output logic             busy,
    output logic             done,
`ifdef TRACEBACK_STEP_CNT_EN
    output logic             error,
    output logic [BitAddr+1:0] step_cnt
`else
    output logic             error
`endif
);

    localparam int W = BitAddr + 1;

    tb_state_e      state;
    logic [W-1:0]   ci, cj;          // current cell
    logic [W-1:0]   nxt_i, nxt_j;    // cell after the step being presented
    logic [W-1:0]   dec_i, dec_j;
    logic           dec_illegal;

    tb_step_decode #(.W(W)) u_decode (
        .dir     (symbol_out),
        .ci      (ci),
        .cj      (cj),
        .next_i  (dec_i),
        .next_j  (dec_j),
        .illegal (dec_illegal)
    );

`ifdef TRACEBACK_STEP_CNT_EN
    logic [W:0] cnt_q;
    assign step_cnt = cnt_q;
`endif

    // Every output is a register; the FSM sets each one on the edge that
    // enters the state where it must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            en_traceB  <= 1'b0;
            i_t        <= '0;
            j_t        <= '0;
            step_valid <= 1'b0;
            step_dir   <= '0;
            step_i     <= '0;
            step_j     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ci         <= '0;
            cj         <= '0;
            nxt_i      <= '0;
            nxt_j      <= '0;
`ifdef TRACEBACK_STEP_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            // NOTE: state is updated with <= only, so every branch below sees
            // the values from before this edge regardless of statement order.
            done  <= 1'b0;
            error <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ci   <= len_i;
                        cj   <= len_j;
                        busy <= 1'b1;
`ifdef TRACEBACK_STEP_CNT_EN
                        cnt_q <= '0;
`endif
                        if (len_i == '0 && len_j == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state     <= ST_READ;
                            en_traceB <= 1'b1;
                            i_t       <= len_i;
                            j_t       <= len_j;
                        end
                    end
                end

                ST_READ: begin
                    en_traceB <= 1'b0;
                    state     <= ST_WAIT;
                end

                // symbol_out is valid here; an illegal arrow aborts before
                // anything reaches the step stream.
                ST_WAIT: begin
                    if (dec_illegal) begin
                        state <= ST_ERR;
                    end else begin
                        step_valid <= 1'b1;
                        step_dir   <= symbol_out;
                        step_i     <= ci;
                        step_j     <= cj;
                        nxt_i      <= dec_i;
                        nxt_j      <= dec_j;
                        state      <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (step_ready) begin
                        step_valid <= 1'b0;
                        ci         <= nxt_i;
                        cj         <= nxt_j;
`ifdef TRACEBACK_STEP_CNT_EN
                        cnt_q      <= cnt_q + 1'b1;
`endif
                        if (nxt_i == '0 && nxt_j == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state     <= ST_READ;
                            en_traceB <= 1'b1;
                            i_t       <= nxt_i;
                            j_t       <= nxt_j;
                        end
                    end
                end

                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                ST_ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
// -----------------------------------------------------------------------------
// tb_traceback_unit
// Drives traceback_unit against a registered direction-RAM model. Expected
// step lists come from walking the RAM contents with the arrow rules directly.
// -----------------------------------------------------------------------------
module tb_traceback_unit;
    import nw_pkg::*;

    localparam int N       = 12;
    localparam int BitAddr = $clog2(N + 1);
    localparam int W       = BitAddr + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     len_i, len_j;
    logic             en_traceB;
    logic [W-1:0]     i_t, j_t;
    logic [2:0]       symbol_out;
    logic             step_valid;
    logic             step_ready;
    logic [2:0]       step_dir;
    logic [W-1:0]     step_i, step_j;
    logic             busy, done, error;
`ifdef TRACEBACK_STEP_CNT_EN
    logic [W:0]       step_cnt;
`endif

    traceback_unit #(.N(N), .BitAddr(BitAddr)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_i      (len_i),
        .len_j      (len_j),
        .en_traceB  (en_traceB),
        .i_t        (i_t),
        .j_t        (j_t),
        .symbol_out (symbol_out),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_dir   (step_dir),
        .step_i     (step_i),
        .step_j     (step_j),
        .busy       (busy),
        .done       (done),
`ifdef TRACEBACK_STEP_CNT_EN
        .error      (error),
        .step_cnt   (step_cnt)
`else
        .error      (error)
`endif
    );

    always #5 clk = ~clk;

    // Direction RAM: registered read, data one cycle after the enable.
    logic [2:0] ram [0:N][0:N];
    int         origin_reads = 0;

    always @(posedge clk) begin
        if (en_traceB) begin
            symbol_out <= ram[i_t][j_t];
            if (i_t == '0 && j_t == '0) origin_reads <= origin_reads + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int exp_i[$], exp_j[$], exp_d[$];
    bit exp_err;

    task automatic build_expected(input int li, input int lj);
        int i, j;
        logic [2:0] d;
        i = li; j = lj;
        exp_i.delete(); exp_j.delete(); exp_d.delete();
        exp_err = 1'b0;
        while (i != 0 || j != 0) begin
            d = ram[i][j];
            if (!((d == DIR_DIAG && i > 0 && j > 0) ||
                  (d == DIR_UP && j > 0) || (d == DIR_LEFT && i > 0))) begin
                exp_err = 1'b1;
                break;
            end
            exp_i.push_back(i); exp_j.push_back(j); exp_d.push_back(int'(d));
            if (d != DIR_UP)   i = i - 1;
            if (d != DIR_LEFT) j = j - 1;
        end
    endtask

    task automatic fill_all(input logic [2:0] code);
        for (int i = 0; i <= N; i++)
            for (int j = 0; j <= N; j++)
                ram[i][j] = code;
    endtask

    // Legal walk everywhere, with an optional sprinkle of corrupt cells.
    task automatic fill_random(input int bad_pct);
        for (int i = 0; i <= N; i++) begin
            for (int j = 0; j <= N; j++) begin
                if (i == 0)      ram[i][j] = DIR_UP;
                else if (j == 0) ram[i][j] = DIR_LEFT;
                else begin
                    case ($urandom_range(2))
                        0:       ram[i][j] = DIR_DIAG;
                        1:       ram[i][j] = DIR_UP;
                        default: ram[i][j] = DIR_LEFT;
                    endcase
                end
                if ($urandom_range(99) < bad_pct) ram[i][j] = 3'($urandom_range(7));
            end
        end
    endtask

    // ---------------- one traceback ----------------
    // stall: percent of cycles with step_ready low; hold_n: first presented
    // cycles forced not-ready; poke: pulse start while busy (must be ignored).
    task automatic run_trace(input int li, input int lj, input int stall,
                             input int hold_n, input bit poke);
        int cyc, done_cyc, reads, nsteps, n_exp, hold_left, got_done, got_err;
        bit fin, hold;
        logic [2:0]   p_dir;
        logic [W-1:0] p_i, p_j;

        build_expected(li, lj);
        n_exp = exp_i.size();
        reads = 0; nsteps = 0; got_done = 0; got_err = 0;
        fin = 1'b0; hold = 1'b0; done_cyc = -1; hold_left = hold_n;
        p_dir = '0; p_i = '0; p_j = '0;

        @(negedge clk);
        start = 1'b1; len_i = W'(li); len_j = W'(lj);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!fin && cyc < 3000) begin
            start = 1'b0;
            if (done)      begin got_done++; fin = 1'b1; done_cyc = cyc; end
            if (error)     begin got_err++;  fin = 1'b1; done_cyc = cyc; end
            if (en_traceB) reads++;
            if (hold) begin
                check("hold_valid", step_valid, 1);
                check("hold_fields", {step_dir, step_i, step_j}, {p_dir, p_i, p_j});
            end
            if (step_valid && hold_left > 0) begin
                step_ready = 1'b0;
                hold_left--;
            end else begin
                step_ready = ($urandom_range(99) >= stall);
            end
            if (step_valid && step_ready) begin
                if (exp_i.size() == 0) begin
                    check("extra_step", 1, 0);
                end else begin
                    check("step_i",   step_i,   exp_i.pop_front());
                    check("step_j",   step_j,   exp_j.pop_front());
                    check("step_dir", step_dir, exp_d.pop_front());
                end
                nsteps++;
                hold = 1'b0;
            end else begin
                hold = step_valid;
            end
            p_dir = step_dir; p_i = step_i; p_j = step_j;
            if (poke && cyc == 2 && busy) begin
                start = 1'b1;
                len_i = W'($urandom_range(N));
                len_j = W'($urandom_range(N));
            end
            @(negedge clk);
            cyc++;
        end
        step_ready = 1'b0;
        start      = 1'b0;

        check("timeout",   fin, 1);
        check("done",      got_done, exp_err ? 0 : 1);
        check("error",     got_err,  exp_err ? 1 : 0);
        check("nsteps",    nsteps, n_exp);
        check("reads",     reads, n_exp + (exp_err ? 1 : 0));
        check("busy_end",  busy, 0);
        check("origin_rd", origin_reads, 0);
        check("bound",     nsteps <= li + lj, 1);
        if (stall == 0 && hold_n == 0)
            check("latency", done_cyc, exp_err ? 3 * n_exp + 3 : 3 * n_exp + 1);
`ifdef TRACEBACK_STEP_CNT_EN
        check("step_cnt",  step_cnt, nsteps);
`endif
        @(negedge clk);
        check("pulse_len", {done, error}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},     en_traceB, 0);
        check({tag, "_addr"},   {i_t, j_t}, 0);
        check({tag, "_valid"},  step_valid, 0);
        check({tag, "_step"},   {step_dir, step_i, step_j}, 0);
        check({tag, "_status"}, {busy, done, error}, 0);
`ifdef TRACEBACK_STEP_CNT_EN
        check({tag, "_cnt"},    step_cnt, 0);
`endif
    endtask

    initial begin
        int ens, cyc;
        rst = 1'b1; start = 1'b0; len_i = '0; len_j = '0; step_ready = 1'b0;
        fill_all(DIR_DIAG);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // All-DIAG diagonal walk.
        fill_all(DIR_DIAG);
        run_trace(3, 3, 0, 0, 1'b0);

        // Pure LEFT along row j=0.
        fill_random(0);
        run_trace(2, 0, 0, 0, 1'b0);

        // Backpressure: ready low for the first 5 presented cycles.
        fill_random(0);
        run_trace(4, 3, 0, 5, 1'b0);

        // Corrupt symbol at the start cell.
        fill_random(0);
        ram[4][4] = 3'b000;
        run_trace(4, 4, 0, 0, 1'b0);

        // Zero-length traceback.
        run_trace(0, 0, 0, 0, 1'b0);

        // Boundary-illegal arrows.
        fill_random(0);
        ram[0][2] = DIR_DIAG;
        run_trace(0, 2, 0, 0, 1'b0);
        ram[3][0] = DIR_UP;
        run_trace(3, 0, 0, 0, 1'b0);
        ram[0][1] = DIR_LEFT;
        run_trace(0, 1, 0, 0, 1'b0);

        // Reset during WAIT of the second step, then a clean run.
        fill_all(DIR_DIAG);
        @(negedge clk);
        start = 1'b1; len_i = W'(5); len_j = W'(5);
        @(negedge clk);
        start = 1'b0; step_ready = 1'b1;
        ens = 0; cyc = 0;
        while (ens < 2 && cyc < 100) begin
            if (en_traceB) ens++;
            if (ens < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("rst_reach_step2", ens, 2);
        @(negedge clk);                 // WAIT of step 2
        step_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        run_trace(3, 2, 0, 0, 1'b0);

        // Randomized tracebacks with stalls, corrupt cells and ignored starts.
        for (int k = 0; k < 30; k++) begin
            fill_random((k % 3 == 0) ? 4 : 0);
            run_trace($urandom_range(N), $urandom_range(N),
                      $urandom_range(60), $urandom_range(3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter N, default 128, max sequence length per string.
REQ-002 SHALL have parameter BitAddr, default $clog2(N+1), coordinate port MSB index (coordinates are BitAddr+1 bits).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching a traceback; ignored unless idle.
REQ-006 SHALL have ports len_i, len_j  input  BitAddr+1  start coordinates, sampled on accepted start.
REQ-007 SHALL have port en_traceB  output  1  direction-RAM read enable.
REQ-008 SHALL have ports i_t, j_t  output  BitAddr+1  direction-RAM read coordinates.
REQ-009 SHALL have port symbol_out  input  3  direction-RAM read data, valid the cycle after en_traceB.
REQ-010 SHALL have ports step_valid, step_ready  output/input  1  step-stream handshake.
REQ-011 SHALL have port step_dir  output  3  arrow of current step (DIAG 001, UP 010, LEFT 100).
REQ-012 SHALL have ports step_i, step_j  output  BitAddr+1  cell coordinates of current step.
REQ-013 SHALL have ports busy, done, error  output  1  status; done and error are one-cycle pulses.

Function
REQ-014 SHALL implement states IDLE, READ, WAIT, EMIT, FINISH, ERR.
REQ-015 IDLE: start=1 SHALL latch (ci,cj)=(len_i,len_j), set busy, go to READ; if len_i=len_j=0 go directly to FINISH.
REQ-016 READ: SHALL drive en_traceB=1, i_t=ci, j_t=cj for exactly one cycle, then WAIT.
REQ-017 WAIT: SHALL capture symbol_out into a register, then EMIT; en_traceB=0.
REQ-018 EMIT: SHALL hold step_valid=1 with stable step_dir/step_i/step_j until step_ready=1; transfer occurs in the cycle both are high.
REQ-019 On transfer: DIAG SHALL decrement ci and cj; UP SHALL decrement cj; LEFT SHALL decrement ci.
REQ-020 After transfer SHALL go to FINISH if new (ci,cj)=(0,0), else READ; minimum 3 cycles per step.
REQ-021 Symbol not in {001,010,100}, DIAG with ci=0 or cj=0, UP with cj=0, or LEFT with ci=0 SHALL go to ERR without emitting the step.
REQ-022 FINISH: SHALL pulse done for one cycle, clear busy, return to IDLE.
REQ-023 ERR: SHALL pulse error for one cycle, clear busy, return to IDLE; no further steps emitted.
REQ-024 Cell (0,0) SHALL never be read or emitted.
REQ-025 start while busy SHALL be ignored; step_ready while step_valid=0 SHALL be ignored.
REQ-026 Step count per traceback SHALL never exceed len_i+len_j.

Reset
REQ-027 rst=1 SHALL force IDLE from any state, including mid-traceback, in the same clock edge.
REQ-028 Reset values: en_traceB=0, i_t=j_t=0, step_valid=0, step_dir=0, step_i=step_j=0, busy=0, done=0, error=0.

Configuration
REQ-029 With TRACEBACK_STEP_CNT_EN defined SHALL add output step_cnt (BitAddr+2 bits): cleared on accepted start, incremented per transfer, held after done/error, reset to 0.
REQ-030 Without TRACEBACK_STEP_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Direction codes (DIAG, UP, LEFT) and the state encoding SHALL live in shared package nw_pkg, also used by the direction-RAM writer.
REQ-032 Sub-module tb_step_decode SHALL be combinational: arrow + (ci,cj) -> next (ci,cj) and illegal flag.

Verification
REQ-033 RAM model all DIAG, len 3/3 -> steps (3,3),(2,2),(1,1) DIAG, then done; 9+ cycles.
REQ-034 len_i=2, len_j=0, boundary LEFT -> steps (2,0),(1,0) LEFT, done; zero UP/DIAG.
REQ-035 step_ready held low 5 cycles in EMIT -> step_valid and fields stable, no extra en_traceB pulses.
REQ-036 Symbol 000 at (4,4) -> no step emitted, error pulse, busy=0 next cycle.
REQ-037 rst asserted during WAIT of step 2 -> all outputs at reset values next cycle; following start runs cleanly.
REQ-038 start with len_i=len_j=0 -> no en_traceB, done pulse 2 cycles after start.
